// File: rtl/uart_component.sv
// UART with a tiny CPU register port: 8N1 transmitter, 8N1 receiver, status/control, level IRQ.
// Latency: read data registered one clock after the read event; TX line starts one clock after the write event.
// Backpressure: none; a TX write while tx_busy is dropped, a new RX byte overwrites an unread one (overrun).
//
// Ports:
//   clock, reset         single rising-edge clock, async active-low reset
//   cs, wr, rd_strobe    chip select (low), write enable (low), read request (high); all edge-detected
//   addr, in_data        register address and write data
//   out_data, rd_busy    registered read data; rd_busy is high in the read-event cycle only
//   rx_in, tx_out        serial in (async, idle high) and serial out (idle high)
//   irq, irq_id, debug   level interrupt, interrupt source (1=RX, 2=TX), status mirror
module uart_component #(
    parameter int CLK_FREQ = 48000000,
    parameter int BAUD     = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       wr,
    input  logic       rd_strobe,
    output logic       rd_busy,
    input  logic [2:0] addr,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    input  logic       rx_in,
    output logic       tx_out,
    output logic       irq,
    output logic [2:0] irq_id,
    output logic [7:0] debug
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    // ---------------- bus edge detection ----------------
    logic wr_act, wr_prev, wr_ev;
    logic rd_act, rd_prev, rd_ev;

    assign wr_act = ~cs & ~wr;
    assign rd_act = rd_strobe & ~cs;
    // Gated by reset so nothing leaks out combinationally while reset is held.
    assign wr_ev  = wr_act & ~wr_prev & reset;
    assign rd_ev  = rd_act & ~rd_prev & reset;
    assign rd_busy = rd_ev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_prev <= 1'b0;
            rd_prev <= 1'b0;
        end else begin
            wr_prev <= wr_act;
            rd_prev <= rd_act;
        end
    end

    // ---------------- registers ----------------
    logic       rx_ready, tx_busy, overrun, frame_err, rx_ie, tx_ie;
    logic [7:0] rx_buf;
    logic [7:0] status;
    logic [7:0] rd_val;
    logic       ctl_wr, rx_read, tx_start;

    assign status   = {2'b00, frame_err, tx_ie, rx_ie, overrun, tx_busy, rx_ready};
    assign ctl_wr   = wr_ev & (addr == 3'd0);
    assign rx_read  = rd_ev & (addr == 3'd1);
    assign tx_start = wr_ev & (addr == 3'd2) & ~tx_busy;

    always_comb begin
        rd_val = 8'h00;
        case (addr)
            3'd0:    rd_val = status;
            3'd1:    rd_val = rx_buf;
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data <= 8'h00;
        end else if (rd_ev) begin
            out_data <= rd_val;
        end
    end

    // ---------------- transmitter ----------------
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bits;
    logic [8:0]    tx_shift;   // remaining data bits plus stop bit, LSB goes out next

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_busy  <= 1'b0;
            tx_out   <= 1'b1;
            tx_cnt   <= '0;
            tx_bits  <= 4'd0;
            tx_shift <= 9'h000;
        end else if (tx_start) begin
            tx_busy  <= 1'b1;
            tx_out   <= 1'b0;          // start bit
            tx_shift <= {1'b1, in_data};
            tx_bits  <= 4'd0;
            tx_cnt   <= DIV_M1;
        end else if (tx_busy) begin
            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - CW'(1);
            end else if (tx_bits == 4'd9) begin
                // Stop bit has been on the line for a full bit time.
                tx_busy <= 1'b0;
            end else begin
                tx_out   <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[8:1]};
                tx_bits  <= tx_bits + 4'd1;
                tx_cnt   <= DIV_M1;
            end
        end
    end

    // ---------------- receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t rx_state, rx_next;

    logic          rx_meta, rx_sync, rx_last;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bits;
    logic [7:0]    rx_shift;
    logic          rx_tick, rx_done_ok, rx_done_err;

    assign rx_tick = (rx_cnt == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_last <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_last <= rx_sync;
        end
    end

    always_comb begin
        rx_next     = rx_state;
        rx_done_ok  = 1'b0;
        rx_done_err = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_last & ~rx_sync) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;   // glitch rejection
            RX_DATA:  if (rx_tick && rx_bits == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_tick) begin
                    rx_next     = RX_IDLE;
                    rx_done_ok  = rx_sync;
                    rx_done_err = ~rx_sync;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_cnt   <= '0;
            rx_bits  <= 3'd0;
            rx_shift <= 8'h00;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    // Preloaded so the start bit is re-checked half a bit after the edge.
                    rx_cnt  <= HALF_M1;
                    rx_bits <= 3'd0;
                end
                RX_START: rx_cnt <= rx_tick ? DIV_M1 : rx_cnt - CW'(1);
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bits  <= rx_bits + 3'd1;
                        rx_cnt   <= DIV_M1;
                    end else begin
                        rx_cnt <= rx_cnt - CW'(1);
                    end
                end
                RX_STOP: if (!rx_tick) rx_cnt <= rx_cnt - CW'(1);
                default: rx_cnt <= HALF_M1;
            endcase
        end
    end

    // ---------------- flags ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_ready  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rx_ie     <= 1'b0;
            tx_ie     <= 1'b0;
            rx_buf    <= 8'h00;
        end else begin
            // A byte landing in the same cycle as a buffer read keeps rx_ready set.
            if (rx_done_ok) begin
                rx_ready <= 1'b1;
                rx_buf   <= rx_shift;
            end else if (rx_read) begin
                rx_ready <= 1'b0;
            end

            if (rx_done_ok && rx_ready && !rx_read) overrun <= 1'b1;
            else if (ctl_wr && in_data[2])          overrun <= 1'b0;

            if (rx_done_err)                        frame_err <= 1'b1;
            else if (ctl_wr && in_data[5])          frame_err <= 1'b0;

            if (ctl_wr) begin
                rx_ie <= in_data[3];
                tx_ie <= in_data[4];
            end
        end
    end

    // ---------------- interrupt and debug ----------------
    logic rx_term, tx_term;
    assign rx_term = rx_ready & rx_ie;
    assign tx_term = ~tx_busy & tx_ie;
    assign irq     = rx_term | tx_term;
    assign irq_id  = rx_term ? 3'd1 : (tx_term ? 3'd2 : 3'd0);
    assign debug   = {4'b0000, tx_busy, overrun, rx_ready, rx_sync};

endmodule

// File: tb/tb_uart_component.sv
module tb_uart_component;

    localparam int DIV = 416;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cs = 1'b1;
    logic       wr = 1'b1;
    logic       rd_strobe = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] in_data = 8'h00;
    logic       rx_in = 1'b1;
    logic       rd_busy;
    logic [7:0] out_data;
    logic       tx_out;
    logic       irq;
    logic [2:0] irq_id;
    logic [7:0] debug;

    uart_component dut (
        .clock(clock), .reset(reset), .cs(cs), .wr(wr), .rd_strobe(rd_strobe),
        .rd_busy(rd_busy), .addr(addr), .in_data(in_data), .out_data(out_data),
        .rx_in(rx_in), .tx_out(tx_out), .irq(irq), .irq_id(irq_id), .debug(debug)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Scoreboards: expected TX line bits and expected RX buffer contents.
    logic       tx_q[$];
    logic [7:0] rx_q[$];
    logic       exp_ovr = 1'b0, exp_ferr = 1'b0, exp_rxie = 1'b0, exp_txie = 1'b0;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d, input int hold);
        addr = a; in_data = d; cs = 1'b0; wr = 1'b0;
        tick(hold);
        cs = 1'b1; wr = 1'b1;
        tick(1);
        if (a == 3'd0) begin
            exp_rxie = d[3];
            exp_txie = d[4];
            if (d[2]) exp_ovr = 1'b0;
            if (d[5]) exp_ferr = 1'b0;
        end
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
        addr = a; cs = 1'b0; rd_strobe = 1'b1;
        #1;
        check("rd_busy_event", rd_busy, 1);
        tick(1);
        check("rd_busy_after", rd_busy, 0);
        d = out_data;
        rd_strobe = 1'b0; cs = 1'b1;
        tick(1);
    endtask

    task automatic check_status(input string tag);
        logic [7:0] d;
        cpu_read(3'd0, d);
        check(tag, d, {2'b00, exp_ferr, exp_txie, exp_rxie, exp_ovr, 1'b0, rx_q.size() != 0});
    endtask

    task automatic rx_pop(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        cpu_read(3'd1, d);
        e = rx_q.pop_front();
        check(tag, d, e);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_in = bits[i];
            tick(DIV);
        end
        rx_in = 1'b1;
        tick(20);
        if (stop) begin
            if (rx_q.size() != 0) begin
                exp_ovr = 1'b1;
                void'(rx_q.pop_front());
            end
            rx_q.push_back(b);
        end else begin
            exp_ferr = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       e;
        int         lows;

        // Reset, with a read request held active to confirm nothing leaks out.
        cs = 1'b0; rd_strobe = 1'b1;
        tick(3);
        check("reset_tx_out", tx_out, 1);
        check("reset_out_data", out_data, 8'h00);
        check("reset_rd_busy", rd_busy, 0);
        check("reset_irq", {irq, irq_id}, 4'h0);
        check("reset_debug_flags", debug[3:1], 3'b000);
        cs = 1'b1; rd_strobe = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);
        check_status("status_after_reset");

        // Unmapped addresses.
        cpu_write(3'd3, 8'hFF, 2);
        cpu_read(3'd5, d);
        check("read_addr5", d, 8'h00);
        cpu_read(3'd2, d);
        check("read_addr2", d, 8'h00);
        check_status("status_after_ignored_write");

        // TX 0x55 with a 5-clock held write; a second write mid-frame must be dropped.
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            d = 8'h55;
            tx_q.push_back(d[i]);
        end
        tx_q.push_back(1'b1);
        addr = 3'd2; in_data = 8'h55; cs = 1'b0; wr = 1'b0;
        tick(1);
        check("tx_busy_set", debug[3], 1);
        for (int k = 0; k < 10; k++) begin
            e = tx_q.pop_front();
            check("tx_bit_start", tx_out, e);
            if (k == 0) begin
                tick(4);
                cs = 1'b1; wr = 1'b1;
                tick(411);
            end else if (k == 5) begin
                addr = 3'd2; in_data = 8'h00; cs = 1'b0; wr = 1'b0;
                tick(3);
                cs = 1'b1; wr = 1'b1;
                tick(412);
            end else begin
                tick(415);
            end
            check("tx_bit_end", tx_out, e);
            if (k == 9) check("tx_busy_last_clock", debug[3], 1);
            tick(1);
        end
        check("tx_busy_cleared", debug[3], 0);
        lows = 0;
        for (int i = 0; i < 1200; i++) begin
            tick(1);
            if (tx_out !== 1'b1) lows++;
        end
        check("tx_single_frame", lows, 0);

        // RX 0xA3 and read-back.
        send_frame(8'hA3, 1'b1);
        check("rx_ready_set", debug[1], 1);
        check_status("status_rx_ready");
        rx_pop("rx_byte_a3");
        check("rx_ready_cleared", debug[1], 0);

        // Overrun.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check_status("status_overrun");
        rx_pop("rx_byte_overwritten");
        cpu_write(3'd0, 8'h04, 2);
        check_status("status_overrun_cleared");

        // Framing error.
        send_frame(8'h5A, 1'b0);
        check_status("status_frame_err");
        cpu_write(3'd0, 8'h20, 2);
        check_status("status_frame_err_cleared");

        // Interrupts.
        cpu_write(3'd0, 8'h18, 1);
        check("irq_tx_idle", {irq, irq_id}, {1'b1, 3'd2});
        send_frame(8'h3C, 1'b1);
        check("irq_rx_wins", {irq, irq_id}, {1'b1, 3'd1});
        rx_pop("rx_byte_3c");
        check("irq_back_to_tx", {irq, irq_id}, {1'b1, 3'd2});

        // Reset in the middle of data bit 3 (line bit 4) of 0xF0.
        addr = 3'd2; in_data = 8'hF0; cs = 1'b0; wr = 1'b0;
        tick(1);
        cs = 1'b1; wr = 1'b1;
        tick(4 * DIV + 100);
        check("tx_bit4_before_reset", tx_out, 0);
        reset = 1'b0;
        #1;
        check("tx_out_abort", tx_out, 1);
        check("irq_in_reset", {irq, irq_id}, 4'h0);
        tick(2);
        reset = 1'b1;
        exp_ovr = 1'b0; exp_ferr = 1'b0; exp_rxie = 1'b0; exp_txie = 1'b0;
        rx_q.delete();
        tick(2);
        check_status("status_after_mid_tx_reset");
        lows = 0;
        for (int i = 0; i < 500; i++) begin
            tick(1);
            if (tx_out !== 1'b1) lows++;
        end
        check("tx_idle_after_reset", lows, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
